// File: rtl/aes_enc_arbiter.sv
// aes_enc_arbiter: round-robin front end sharing one AES-128 core between two requesters.
// Define AES_ARB_KEY_CACHE_EN to skip the key reload when a request reuses the last loaded key.
module aes_enc_arbiter #(
  parameter int TMO_CYC = 32
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [1:0]   req_vld,
  output logic [1:0]   req_rdy,
  input  logic [255:0] req_key,
  input  logic [255:0] req_din,
  output logic [1:0]   rsp_vld,
  input  logic [1:0]   rsp_rdy,
  output logic [127:0] rsp_dout,
  output logic         rsp_err,
  output logic [127:0] aes_Kin,
  output logic [127:0] aes_Din,
  output logic         aes_Krdy,
  output logic         aes_Drdy,
  output logic         aes_EN,
  input  logic [127:0] aes_Dout,
  input  logic         aes_Kvld,
  input  logic         aes_Dvld,
  input  logic         aes_BSY,
  output logic         busy
);

  localparam int CNT_W = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_LD   = 3'd1,
    KEY_WAIT = 3'd2,
    DAT_ST   = 3'd3,
    DAT_WAIT = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             gnt_s;
  logic             gnt_r;
  logic             rr_r;
  logic [127:0]     cap_key_s;
  logic [127:0]     cap_din_s;
  logic [127:0]     key_r;
  logic [127:0]     din_r;
  logic             need_key_s;
  logic             start_s;
  logic             key_done_s;
  logic             dat_done_s;
  logic             tmo_s;
  logic [1:0]       req_rdy_r;
  logic [1:0]       rsp_vld_r;
  logic [127:0]     rsp_dout_r;
  logic             rsp_err_r;
  logic             krdy_r;
  logic             drdy_r;
  logic             busy_r;

  // Round-robin pick among pending requesters; rr_r holds the previous winner
  always_comb begin
    gnt_s = 1'b0;
    case (req_vld)
      2'b01:   gnt_s = 1'b0;
      2'b10:   gnt_s = 1'b1;
      2'b11:   gnt_s = ~rr_r;
      default: gnt_s = 1'b0;
    endcase
  end

  assign cap_key_s  = gnt_s ? req_key[255:128] : req_key[127:0];
  assign cap_din_s  = gnt_s ? req_din[255:128] : req_din[127:0];
  // A grant is only issued while the core is idle so Krdy/Drdy never meet BSY=1
  assign start_s    = (state_r == IDLE) && (req_vld != 2'b00) && !aes_BSY;
  assign key_done_s = (state_r == KEY_WAIT) && aes_Kvld && !aes_BSY;
  assign dat_done_s = (state_r == DAT_WAIT) && aes_Dvld && !aes_BSY;

`ifdef AES_ARB_KEY_CACHE_EN
  logic [127:0] kc_key_r;
  logic         kc_vld_r;

  // Key cache: filled when the core confirms a key, dropped on any timeout
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      kc_key_r <= 128'd0;
      kc_vld_r <= 1'b0;
    end else if (tmo_s) begin
      kc_key_r <= kc_key_r;
      kc_vld_r <= 1'b0;
    end else if (key_done_s) begin
      kc_key_r <= key_r;
      kc_vld_r <= 1'b1;
    end else begin
      kc_key_r <= kc_key_r;
      kc_vld_r <= kc_vld_r;
    end
  end

  assign need_key_s = !(kc_vld_r && (cap_key_s == kc_key_r));
`else
  assign need_key_s = 1'b1;
`endif

  // Next-state decode; a completing handshake takes priority over the timeout
  always_comb begin
    state_nx_s = state_r;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (need_key_s) begin
            state_nx_s = KEY_LD;
          end else begin
            state_nx_s = DAT_ST;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      KEY_LD: begin
        state_nx_s = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (key_done_s) begin
          state_nx_s = DAT_ST;
        end else if (cnt_r == TMO_LIM) begin
          state_nx_s = RESP;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = KEY_WAIT;
        end
      end
      DAT_ST: begin
        state_nx_s = DAT_WAIT;
      end
      DAT_WAIT: begin
        if (dat_done_s) begin
          state_nx_s = RESP;
        end else if (cnt_r == TMO_LIM) begin
          state_nx_s = RESP;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = DAT_WAIT;
        end
      end
      RESP: begin
        if (rsp_rdy[gnt_r]) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and wait-state timeout counter (cleared on every state change)
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == KEY_WAIT) || (state_r == DAT_WAIT)) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Grant capture: channel, pointer, key/plaintext and the one-cycle accept pulse
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      gnt_r     <= 1'b0;
      rr_r      <= 1'b1;
      key_r     <= 128'd0;
      din_r     <= 128'd0;
      req_rdy_r <= 2'b00;
    end else if (start_s) begin
      gnt_r     <= gnt_s;
      rr_r      <= gnt_s;
      key_r     <= cap_key_s;
      din_r     <= cap_din_s;
      req_rdy_r <= gnt_s ? 2'b10 : 2'b01;
    end else begin
      gnt_r     <= gnt_r;
      rr_r      <= rr_r;
      key_r     <= key_r;
      din_r     <= din_r;
      req_rdy_r <= 2'b00;
    end
  end

  // Result register: ciphertext on completion, zero plus error flag on timeout
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rsp_dout_r <= 128'd0;
      rsp_err_r  <= 1'b0;
    end else if (dat_done_s) begin
      rsp_dout_r <= aes_Dout;
      rsp_err_r  <= 1'b0;
    end else if (tmo_s) begin
      rsp_dout_r <= 128'd0;
      rsp_err_r  <= 1'b1;
    end else begin
      rsp_dout_r <= rsp_dout_r;
      rsp_err_r  <= rsp_err_r;
    end
  end

  // Moore strobes registered from the next state so each is high exactly in its state
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      krdy_r    <= 1'b0;
      drdy_r    <= 1'b0;
      busy_r    <= 1'b0;
      rsp_vld_r <= 2'b00;
    end else begin
      krdy_r    <= (state_nx_s == KEY_LD);
      drdy_r    <= (state_nx_s == DAT_ST);
      busy_r    <= (state_nx_s != IDLE);
      rsp_vld_r <= (state_nx_s == RESP) ? (gnt_r ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign req_rdy  = req_rdy_r;
  assign rsp_vld  = rsp_vld_r;
  assign rsp_dout = rsp_dout_r;
  assign rsp_err  = rsp_err_r;
  assign aes_Kin  = key_r;
  assign aes_Din  = din_r;
  assign aes_Krdy = krdy_r;
  assign aes_Drdy = drdy_r;
  assign busy     = busy_r;
  // The core is enabled for as long as the block is out of reset
  assign aes_EN   = RSTn;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// tb_aes_enc_arbiter: table-driven scoreboard bench around a behavioural AES core stand-in.
module tb_aes_enc_arbiter;

  localparam logic [127:0] KAT_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] K3 = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] P5 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P6 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         CLK;
  logic         RSTn;
  logic [1:0]   req_vld;
  logic [1:0]   req_rdy;
  logic [255:0] req_key;
  logic [255:0] req_din;
  logic [1:0]   rsp_vld;
  logic [1:0]   rsp_rdy;
  logic [127:0] rsp_dout;
  logic         rsp_err;
  logic [127:0] aes_Kin;
  logic [127:0] aes_Din;
  logic         aes_Krdy;
  logic         aes_Drdy;
  logic         aes_EN;
  logic [127:0] aes_Dout;
  logic         aes_Kvld;
  logic         aes_Dvld;
  logic         aes_BSY;
  logic         busy;

  aes_enc_arbiter #(.TMO_CYC(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_key(req_key), .req_din(req_din),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout), .rsp_err(rsp_err),
    .aes_Kin(aes_Kin), .aes_Din(aes_Din), .aes_Krdy(aes_Krdy), .aes_Drdy(aes_Drdy),
    .aes_EN(aes_EN), .aes_Dout(aes_Dout), .aes_Kvld(aes_Kvld), .aes_Dvld(aes_Dvld),
    .aes_BSY(aes_BSY), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in cipher: the FIPS-197 vector maps to its real ciphertext, anything else is scrambled
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if ((k == KAT_K) && (d == KAT_P)) return KAT_C;
    return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [1:0] onehot(input int ch);
    return (ch == 1) ? 2'b10 : 2'b01;
  endfunction

  // Core model: key load 4 cycles, encryption 6 cycles; Dvld is a level held until the next Drdy
  logic [127:0] core_key;
  logic [127:0] core_din;
  int           kcnt;
  int           dcnt;
  bit           hang;
  int           krdy_cnt;
  int           viol_cnt;
  int           cyc;
  int           drdy_cyc;

  always @(posedge CLK) begin
    if ((aes_Krdy && aes_Drdy) || ((aes_Krdy || aes_Drdy) && aes_BSY)) viol_cnt <= viol_cnt + 1;
    if (aes_Krdy) krdy_cnt <= krdy_cnt + 1;
    if (!aes_EN) begin
      aes_BSY <= 1'b0; aes_Kvld <= 1'b0; aes_Dvld <= 1'b0; kcnt <= 0; dcnt <= 0;
    end else begin
      aes_Kvld <= 1'b0;
      if (aes_Krdy) begin
        core_key <= aes_Kin; aes_BSY <= 1'b1; kcnt <= 4;
      end else if (aes_Drdy) begin
        core_din <= aes_Din; aes_BSY <= 1'b1; aes_Dvld <= 1'b0; dcnt <= 6;
      end else if (kcnt != 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) begin aes_BSY <= 1'b0; aes_Kvld <= 1'b1; end
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          aes_BSY <= 1'b0;
          if (!hang) begin aes_Dvld <= 1'b1; aes_Dout <= core_fn(core_key, core_din); end
        end
      end
    end
  end

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (aes_Drdy) drdy_cyc <= cyc;
  end

  typedef struct packed {
    logic [1:0]   vld;
    logic [127:0] dout;
    logic         err;
  } exp_t;

  typedef struct {
    int           ch;
    logic [127:0] key;
    logic [127:0] pt;
    bit           hng;
    bit           pre;
    int           dly;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[6];
  int           n_tests;
  int           n_fail;
  bit           bc_vld;
  logic [127:0] bc_key;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic start_req(input int ch, input logic [127:0] k, input logic [127:0] p);
    req_key[ch*128 +: 128] = k;
    req_din[ch*128 +: 128] = p;
    req_vld[ch] = 1'b1;
  endtask

  // One full transaction on an already-raised request: grant, response, backpressure, handshake
  task automatic run_op(input int ch, input logic [127:0] k, input logic [127:0] p,
                        input bit hng, input bit pre, input int dly);
    int t;
    int kc0;
    bit ld;
    exp_t e;
    exp_t q;
    logic [127:0] hold;
    kc0  = krdy_cnt;
    hang = hng;
    if (pre) rsp_rdy[ch] = 1'b1;
    t = 0;
    while ((req_rdy == 2'b00) && (t < 100)) begin @(negedge CLK); t++; end
    check("grant_seen", (t < 100), 1);
    check("req_rdy_channel", req_rdy, onehot(ch));
    req_vld[ch] = 1'b0;
`ifdef AES_ARB_KEY_CACHE_EN
    ld = !(bc_vld && (bc_key == k));
`else
    ld = 1'b1;
`endif
    e.vld  = onehot(ch);
    e.dout = hng ? 128'd0 : core_fn(k, p);
    e.err  = hng;
    sb_q.push_back(e);
    t = 0;
    while ((rsp_vld == 2'b00) && (t < 300)) begin @(negedge CLK); t++; end
    check("rsp_seen", (t < 300), 1);
    q = sb_q.pop_front();
    check("rsp_vld", rsp_vld, q.vld);
    check("rsp_dout", rsp_dout, q.dout);
    check("rsp_err", rsp_err, q.err);
    if (hng) check("timeout_latency", cyc - drdy_cyc - 1, 33);
    hold = rsp_dout;
    for (int i = 0; i < dly; i++) begin
      @(negedge CLK);
      check("bp_rsp_vld", rsp_vld, q.vld);
      check("bp_rsp_dout", rsp_dout, hold);
      check("bp_no_grant", req_rdy, 2'b00);
    end
    rsp_rdy[ch] = 1'b1;
    @(negedge CLK);
    check("rsp_vld_drop", rsp_vld, 2'b00);
    rsp_rdy[ch] = 1'b0;
    check("krdy_pulses", krdy_cnt - kc0, ld);
    if (hng) bc_vld = 1'b0;
    else if (ld) begin bc_vld = 1'b1; bc_key = k; end
    hang = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    vecs[0] = '{1, K1,    P2,    1'b0, 1'b0, 3};
    vecs[1] = '{0, K2,    P3,    1'b0, 1'b1, 0};
    vecs[2] = '{0, K2,    P4,    1'b1, 1'b0, 2};
    vecs[3] = '{0, K2,    P5,    1'b0, 1'b0, 1};
    vecs[4] = '{1, KAT_K, KAT_P, 1'b0, 1'b0, 0};
    vecs[5] = '{1, K2,    P1,    1'b0, 1'b1, 0};
    n_tests = 0; n_fail = 0; krdy_cnt = 0; viol_cnt = 0; cyc = 0; drdy_cyc = 0;
    kcnt = 0; dcnt = 0; hang = 1'b0; bc_vld = 1'b0; bc_key = 128'd0;
    core_key = 128'd0; core_din = 128'd0; aes_Dout = 128'd0;
    aes_BSY = 1'b0; aes_Kvld = 1'b0; aes_Dvld = 1'b0;
    RSTn = 1'b0; req_vld = 2'b00; req_key = 256'd0; req_din = 256'd0; rsp_rdy = 2'b00;
    repeat (3) @(negedge CLK);
    check("rst_req_rdy", req_rdy, 2'b00);
    check("rst_rsp_vld", rsp_vld, 2'b00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_dout", rsp_dout, 128'd0);
    check("rst_krdy", aes_Krdy, 1'b0);
    check("rst_drdy", aes_Drdy, 1'b0);
    check("rst_aes_en", aes_EN, 1'b0);
    check("rst_busy", busy, 1'b0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("aes_en_run", aes_EN, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Tie right after reset: channel 0 (known-answer vector) first under 20 cycles of backpressure
    start_req(0, KAT_K, KAT_P);
    start_req(1, K1, P1);
    run_op(0, KAT_K, KAT_P, 1'b0, 1'b0, 20);
    run_op(1, K1, P1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      start_req(vecs[i].ch, vecs[i].key, vecs[i].pt);
      run_op(vecs[i].ch, vecs[i].key, vecs[i].pt, vecs[i].hng, vecs[i].pre, vecs[i].dly);
    end

    // Reset while waiting for ciphertext: no response, outputs cleared, cache forgotten
    start_req(0, K3, P6);
    hang = 1'b1;
    t = 0;
    while ((req_rdy == 2'b00) && (t < 100)) begin @(negedge CLK); t++; end
    check("abort_grant_seen", (t < 100), 1);
    req_vld[0] = 1'b0;
    t = 0;
    while (!aes_Drdy && (t < 100)) begin @(negedge CLK); t++; end
    check("abort_drdy_seen", (t < 100), 1);
    repeat (4) @(negedge CLK);
    check("abort_busy_before", busy, 1'b1);
    RSTn = 1'b0;
    @(negedge CLK);
    check("abort_busy", busy, 1'b0);
    check("abort_rsp_vld", rsp_vld, 2'b00);
    check("abort_rsp_dout", rsp_dout, 128'd0);
    check("abort_rsp_err", rsp_err, 1'b0);
    check("abort_req_rdy", req_rdy, 2'b00);
    check("abort_krdy", aes_Krdy, 1'b0);
    check("abort_drdy", aes_Drdy, 1'b0);
    check("abort_aes_en", aes_EN, 1'b0);
    RSTn = 1'b1;
    hang = 1'b0;
    bc_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("abort_no_rsp", rsp_vld, 2'b00);
    end
    // Last grant before reset was channel 0, so a tie now only favours 0 if the pointer was reset
    start_req(0, K3, P6);
    start_req(1, K1, P3);
    run_op(0, K3, P6, 1'b0, 1'b0, 0);
    run_op(1, K1, P3, 1'b0, 1'b0, 1);

    check("core_protocol_violations", viol_cnt, 0);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_enc_arbiter.md
AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 SHALL have parameter TMO_CYC, default 32, meaning the maximum number of cycles to wait in KEY_WAIT or DAT_WAIT before aborting.
REQ-002 SHALL have port CLK, input, 1, system clock; every flop changes only on the rising edge.
REQ-003 SHALL have port RSTn, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port req_vld, input, 2, per-channel encryption request.
REQ-005 SHALL have port req_rdy, output, 2, one-cycle accept pulse for the granted channel.
REQ-006 SHALL have port req_key, input, 256, channel i key at bits [128i+127:128i].
REQ-007 SHALL have port req_din, input, 256, channel i plaintext at bits [128i+127:128i].
REQ-008 SHALL have port rsp_vld, output, 2, per-channel result valid.
REQ-009 SHALL have port rsp_rdy, input, 2, per-channel result taken.
REQ-010 SHALL have port rsp_dout, output, 128, ciphertext, or zero on error.
REQ-011 SHALL have port rsp_err, output, 1, result aborted by timeout; qualified by rsp_vld.
REQ-012 SHALL have ports aes_Kin, output, 128, and aes_Din, output, 128, both driven to the AES core.
REQ-013 SHALL have ports aes_Krdy, output, 1, aes_Drdy, output, 1, and aes_EN, output, 1, driven to the AES core.
REQ-014 SHALL have ports aes_Dout, input, 128, aes_Kvld, input, 1, aes_Dvld, input, 1, and aes_BSY, input, 1, driven from the AES core.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, KEY_LD, KEY_WAIT, DAT_ST, DAT_WAIT and RESP.
REQ-017 IDLE, arbitration: with one req_vld bit set, that channel is granted; with both set, the channel not granted last time is granted (round-robin pointer).
REQ-018 IDLE, capture: in the grant cycle, req_rdy[g] SHALL pulse, and req_key[g] and req_din[g] SHALL be captured into internal registers.
REQ-019 Key decision: if a key reload is needed, the next state SHALL be KEY_LD; otherwise it SHALL be DAT_ST.
REQ-020 KEY_LD: aes_Krdy=1 for exactly one cycle with aes_Kin equal to the captured key; the next state SHALL be KEY_WAIT.
REQ-021 KEY_WAIT: on aes_Kvld=1 and aes_BSY=0, the next state SHALL be DAT_ST.
REQ-022 DAT_ST: aes_Drdy=1 for exactly one cycle with aes_Din equal to the captured plaintext; the next state SHALL be DAT_WAIT.
REQ-023 DAT_WAIT: on aes_Dvld=1 and aes_BSY=0, aes_Dout SHALL be registered into rsp_dout and the next state SHALL be RESP.
REQ-024 The aes_Dvld level left high by the previous operation SHALL be ignored during the DAT_ST cycle.
REQ-025 RESP: rsp_vld[g]=1, with rsp_dout and rsp_err held stable, until rsp_rdy[g]=1; the next state SHALL then be IDLE.
REQ-026 rsp_vld SHALL rise in the cycle after the completing aes_Dvld sample.
REQ-027 No new grant SHALL occur while any response is pending; at most one operation is outstanding.
REQ-028 aes_Krdy and aes_Drdy SHALL never be high together, and neither SHALL be asserted while aes_BSY=1.
REQ-029 Timeout: a counter of width ceil(log2(TMO_CYC+1)) SHALL clear on entry to KEY_WAIT or DAT_WAIT and increment each cycle spent there.
REQ-030 When the counter reaches TMO_CYC, the FSM SHALL go to RESP with rsp_err=1 and rsp_dout=0, and the key cache SHALL be invalidated.
REQ-031 If rsp_rdy[g] is already high on entry to RESP, the handshake SHALL complete in that same cycle.
REQ-032 req_vld bits of non-granted channels SHALL be ignored until IDLE is reached again; requesters hold req_vld until they see req_rdy.
REQ-033 aes_EN SHALL be 1 whenever RSTn=1.

Reset
REQ-034 With RSTn=0 at a clock edge: state=IDLE, req_rdy=0, rsp_vld=0, rsp_err=0, rsp_dout=0, aes_Krdy=0, aes_Drdy=0, aes_EN=0, busy=0, round-robin pointer=1 (so channel 0 wins the first tie), key cache invalid, timeout counter=0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no response issued to the requester.

Configuration
REQ-036 With macro AES_ARB_KEY_CACHE_EN defined, the block SHALL keep a 128-bit copy of the last successfully loaded key plus a valid bit.
REQ-037 With AES_ARB_KEY_CACHE_EN defined, KEY_LD SHALL be skipped when the cache is valid and the captured key equals the cached copy; the cache SHALL be updated in the KEY_WAIT exit cycle.
REQ-038 With AES_ARB_KEY_CACHE_EN undefined, every operation SHALL pass through KEY_LD and KEY_WAIT, and no cache registers SHALL exist.

Verification
REQ-039 Known-answer: channel 0, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> rsp_vld[0]=1, rsp_dout=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
REQ-040 Simultaneous requests: both req_vld raised in the cycle after reset -> channel 0 granted first, then channel 1, and each response carries that channel's own ciphertext.
REQ-041 Key cache: same key sent twice on channel 1 -> exactly one aes_Krdy pulse with AES_ARB_KEY_CACHE_EN defined, and two pulses without it.
REQ-042 Timeout: core model never raises aes_Dvld, TMO_CYC=32 -> rsp_err=1 and rsp_dout=0, 33 cycles after DAT_WAIT entry.
REQ-043 Backpressure: rsp_rdy[0] held low for 20 cycles -> rsp_vld[0] and rsp_dout stay stable, and channel 1 is not granted until the handshake completes.
REQ-044 Reset in DAT_WAIT -> all outputs at reset values the next cycle; a following request reloads the key (cache invalid).
